alu8_nibble_seq: RTL and testbench

Sequencer that runs one 8-bit ALU operation through the team's 4-bit ALU slice in two passes: low nibble first, then high nibble with the low-pass carry chained in. It sits directly upstream of the 4-bit ALU, driving its `a`/`b`/`cin`/`s` inputs. It also consumes that ALU's `ALU_OUT`/`ALU_COUT`, assembling the 8-bit result and carry-out behind a valid/ready handshake.

---
 rtl/alu8_nibble_seq_pkg.sv | 18 +
 rtl/alu8_nibble_seq_if.sv | 37 +++
 rtl/alu8_nibble_seq.sv | 134 +++++++++++++
 tb/tb_alu8_nibble_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_nibble_seq_pkg.sv
// Shared definitions for the 8-bit two-pass nibble sequencer and its 4-bit ALU slice.
package alu8_pkg;

  localparam int NIB_W     = 4;
  localparam int DATA_W    = 2 * NIB_W;
  localparam int ALU_SEL_W = 3;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_AND = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu8_nibble_seq_if.sv
// Request, slice and result signals of alu8_nibble_seq; slave is the sequencer side.
interface alu8_nibble_seq_if #(
  parameter int NIB_W  = alu8_pkg::NIB_W,
  parameter int DATA_W = alu8_pkg::DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_op;
  logic              in_cin;

  logic [NIB_W-1:0]  alu_a;
  logic [NIB_W-1:0]  alu_b;
  logic              alu_cin;
  logic [2:0]        alu_s;
  logic [NIB_W-1:0]  alu_out;
  logic              alu_cout;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_cout;
  logic              out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, alu_out, alu_cout, out_ready,
    output in_ready, alu_a, alu_b, alu_cin, alu_s, out_valid, out_result, out_cout, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, alu_out, alu_cout, out_ready,
    input  in_ready, alu_a, alu_b, alu_cin, alu_s, out_valid, out_result, out_cout, out_zero
  );

endinterface

// File: rtl/alu8_nibble_seq.sv
// Runs one 8-bit op through a 4-bit ALU slice: low nibble, then high nibble with carry chained.
// Optional zero flag is built only when ALU8_SEQ_ZERO_FLAG_EN is defined.
module alu8_nibble_seq
  import alu8_pkg::*;
#(
  parameter int NIB_W  = alu8_pkg::NIB_W,
  parameter int DATA_W = alu8_pkg::DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  alu8_nibble_seq_if.slave  bus
);

  seq_state_e            state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [ALU_SEL_W-1:0]  op_q, op_d;
  logic                  cin_q, cin_d;
  logic                  carry_q, carry_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic                  cout_q, cout_d;
  logic                  zero_q, zero_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {DATA_W{1'b0}};
      b_q     <= {DATA_W{1'b0}};
      op_q    <= {ALU_SEL_W{1'b0}};
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= {DATA_W{1'b0}};
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          op_d    = bus.in_op;
          cin_d   = bus.in_cin;
          state_d = ST_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        res_d[NIB_W-1:0] = bus.alu_out;
        carry_d          = bus.alu_cout;
        state_d          = ST_HI;
      end
      ST_HI: begin
        res_d[DATA_W-1:NIB_W] = bus.alu_out;
        cout_d                = bus.alu_cout;
`ifdef ALU8_SEQ_ZERO_FLAG_EN
        zero_d = ({bus.alu_out, res_q[NIB_W-1:0]} == {DATA_W{1'b0}});
`else
        zero_d = 1'b0;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slice drive is decoded purely from state and registers, never from in_*
  always_comb begin
    bus.alu_a   = {NIB_W{1'b0}};
    bus.alu_b   = {NIB_W{1'b0}};
    bus.alu_cin = 1'b0;
    bus.alu_s   = {ALU_SEL_W{1'b0}};
    case (state_q)
      ST_LO: begin
        bus.alu_a   = a_q[NIB_W-1:0];
        bus.alu_b   = b_q[NIB_W-1:0];
        bus.alu_cin = cin_q;
        bus.alu_s   = op_q;
      end
      ST_HI: begin
        bus.alu_a   = a_q[DATA_W-1:NIB_W];
        bus.alu_b   = b_q[DATA_W-1:NIB_W];
        bus.alu_cin = carry_q;
        bus.alu_s   = op_q;
      end
      default: begin
        bus.alu_a   = {NIB_W{1'b0}};
        bus.alu_b   = {NIB_W{1'b0}};
        bus.alu_cin = 1'b0;
        bus.alu_s   = {ALU_SEL_W{1'b0}};
      end
    endcase
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = res_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_zero   = zero_q;

endmodule

// File: tb/tb_alu8_nibble_seq.sv
// Closed-loop bench: alu8_nibble_seq driving a behavioural 4-bit slice stub, vector table plus scoreboard.
module tb_alu8_nibble_seq;
  import alu8_pkg::*;

`ifdef ALU8_SEQ_ZERO_FLAG_EN
  localparam bit ZF_EN = 1'b1;
`else
  localparam bit ZF_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    int         hold;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   last_accept;
  vec_t vecs[11];
  exp_t sb[$];

  alu8_nibble_seq_if bus ();

  alu8_nibble_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 4-bit slice stub: 000 = add with carry, 100 = AND with cout 0
  always_comb begin
    case (bus.alu_s)
      3'b000:  {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0000, bus.alu_cin};
      3'b100:  {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_a & bus.alu_b};
      default: {bus.alu_cout, bus.alu_out} = 5'b00000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),   32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid),  32'd0);
    chk({tag, "_result"},    32'(bus.out_result), 32'd0);
    chk({tag, "_cout"},      32'(bus.out_cout),   32'd0);
    chk({tag, "_zero"},      32'(bus.out_zero),   32'd0);
    chk({tag, "_alu_a"},     32'(bus.alu_a),      32'd0);
    chk({tag, "_alu_b"},     32'(bus.alu_b),      32'd0);
    chk({tag, "_alu_cin"},   32'(bus.alu_cin),    32'd0);
    chk({tag, "_alu_s"},     32'(bus.alu_s),      32'd0);
  endtask

  // Drive one request through accept/LO/HI/DONE; called just after a rising edge, in IDLE
  task automatic run(input vec_t v, input bit check_spacing);
    logic [4:0] lo_sum;
    logic       lo_c;
    exp_t       e;
    exp_t       got;
    lo_sum = {1'b0, v.a[3:0]} + {1'b0, v.b[3:0]} + {4'b0000, v.cin};
    lo_c   = (v.op == 3'b000) ? lo_sum[4] : 1'b0;
    e.res  = v.res;
    e.cout = v.cout;
    e.zero = ZF_EN ? (v.res == 8'h00) : 1'b0;

    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_op     = v.op;
    bus.in_cin    = v.cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = (v.hold == 0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    sb.push_back(e);
    if (check_spacing) chk("issue_interval", 32'(cyc - last_accept), 32'd4);
    last_accept  = cyc;
    bus.in_valid = 1'b0;

    chk("lo_alu_a",    32'(bus.alu_a),     32'(v.a[3:0]));
    chk("lo_alu_b",    32'(bus.alu_b),     32'(v.b[3:0]));
    chk("lo_alu_cin",  32'(bus.alu_cin),   32'(v.cin));
    chk("lo_alu_s",    32'(bus.alu_s),     32'(v.op));
    chk("lo_in_ready", 32'(bus.in_ready),  32'd0);
    chk("lo_valid",    32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("hi_alu_a",   32'(bus.alu_a),     32'(v.a[7:4]));
    chk("hi_alu_b",   32'(bus.alu_b),     32'(v.b[7:4]));
    chk("hi_alu_cin", 32'(bus.alu_cin),   32'(lo_c));
    chk("hi_alu_s",   32'(bus.alu_s),     32'(v.op));
    chk("hi_valid",   32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("done_valid_latency", 32'(bus.out_valid), 32'd1);
    chk("done_alu_a",         32'(bus.alu_a),     32'd0);

    // Backpressure: a competing request must not be taken while DONE holds
    for (int h = 0; h < v.hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'h55;
      bus.in_b     = 8'h66;
      chk("bp_valid",    32'(bus.out_valid),  32'd1);
      chk("bp_in_ready", 32'(bus.in_ready),   32'd0);
      chk("bp_result",   32'(bus.out_result), 32'(v.res));
      chk("bp_cout",     32'(bus.out_cout),   32'(v.cout));
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("result", 32'(bus.out_result), 32'(got.res));
      chk("cout",   32'(bus.out_cout),   32'(got.cout));
      chk("zero",   32'(bus.out_zero),   32'(got.zero));
    end
    @(posedge clk);
    #1;
    chk("ret_in_ready",  32'(bus.in_ready),  32'd1);
    chk("ret_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    cyc           = 0;
    last_accept   = -1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_op     = 3'b000;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    //            a      b      op      cin   res    cout  hold
    vecs[0]  = '{8'h8F, 8'h01, 3'b000, 1'b0, 8'h90, 1'b0, 0};
    vecs[1]  = '{8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 0};
    vecs[2]  = '{8'hF0, 8'h3C, 3'b100, 1'b0, 8'h30, 1'b0, 0};
    vecs[3]  = '{8'h12, 8'h34, 3'b000, 1'b1, 8'h47, 1'b0, 0};
    vecs[4]  = '{8'h80, 8'h80, 3'b000, 1'b0, 8'h00, 1'b1, 0};
    vecs[5]  = '{8'h7F, 8'h00, 3'b000, 1'b1, 8'h80, 1'b0, 0};
    vecs[6]  = '{8'hFF, 8'hFF, 3'b000, 1'b1, 8'hFF, 1'b1, 0};
    vecs[7]  = '{8'hA5, 8'h5A, 3'b100, 1'b1, 8'h00, 1'b0, 0};
    vecs[8]  = '{8'h3C, 8'hC4, 3'b000, 1'b0, 8'h00, 1'b1, 5};
    vecs[9]  = '{8'h0F, 8'hF0, 3'b000, 1'b1, 8'h00, 1'b1, 0};
    vecs[10] = '{8'h01, 8'h02, 3'b100, 1'b0, 8'h00, 1'b0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("reset");

    for (int i = 0; i < 11; i++) begin
      run(vecs[i], (i > 0) && (vecs[i-1].hold == 0));
    end

    // Reset during HI discards the operation
    bus.in_a      = 8'h8F;
    bus.in_b      = 8'h01;
    bus.in_op     = 3'b000;
    bus.in_cin    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_hi_alu_a", 32'(bus.alu_a), 32'd8);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
